sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_pkg.sv | 19 +
 rtl/sdram_arb_prio.sv | 27 ++
 rtl/sdram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sdram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM slot arbiter: grant encoding, FSM states
// and internal counter widths.
package sdram_arbiter_pkg;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_DL   = 2'd1;
    localparam logic [1:0] GNT_ER   = 2'd2;
    localparam logic [1:0] GNT_CPU  = 2'd3;

    // Slot counter covers up to 16 cycles; starvation counter saturates at 15.
    localparam int CNT_W    = 4;
    localparam int STARVE_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

endpackage

// File: rtl/sdram_arb_prio.sv
// Fixed-priority requester selection (downloader > eraser > CPU) with a
// starvation override that hands the slot to a waiting CPU.
module sdram_arb_prio
    import sdram_arbiter_pkg::*;
(
    input  logic       dl_req_i,
    input  logic       er_req_i,
    input  logic       cpu_req_i,
    input  logic       starve_i,
    output logic [1:0] winner_o
);

    always_comb begin
        // NOTE: default first so every path assigns winner_o and no latch is inferred.
        winner_o = GNT_NONE;
        if (starve_i && cpu_req_i) begin
            winner_o = GNT_CPU;
        end else if (dl_req_i) begin
            winner_o = GNT_DL;
        end else if (er_req_i) begin
            winner_o = GNT_ER;
        end else if (cpu_req_i) begin
            winner_o = GNT_CPU;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Slot-based arbiter sharing one SDRAM controller port between downloader,
// eraser and CPU; each grant owns the port for SLOT_CYCLES cycles.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int AW           = 25,
    parameter int SLOT_CYCLES  = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          sys_clock,
    input  logic          reset_n,
    input  logic          slot_ena,
    input  logic          dl_req,
    input  logic          dl_we,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_din,
    input  logic          er_req,
    input  logic          er_we,
    input  logic [AW-1:0] er_addr,
    input  logic [7:0]    er_din,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [15:0]   cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          dl_ack,
    output logic          er_ack,
    output logic          cpu_ack,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          mem_oe,
    input  logic [7:0]    mem_dout,
    output logic [1:0]    grant,
    output logic          slot_overrun
);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [1:0]            grant_q, winner;
    logic                  dl_ack_q, er_ack_q, cpu_ack_q;
    logic [7:0]            rd_data_q, mem_din_q;
    logic [AW-1:0]         mem_addr_q;
    logic                  mem_we_q, mem_oe_q, overrun_q;

    logic                  any_req, starve, last_cycle, arb_now;
    logic [AW-1:0]         sel_addr;
    logic [7:0]            sel_din;
    logic                  sel_we;

    assign any_req    = dl_req | er_req | cpu_req;
    assign starve     = (starve_q >= STARVE_W'(STARVE_LIMIT));
    assign last_cycle = (state_q == ST_ACCESS) && (cnt_q == CNT_W'(SLOT_CYCLES - 1));
    // A slot arriving on the final access cycle starts the next access with no gap.
    assign arb_now    = slot_ena && any_req && ((state_q == ST_IDLE) || last_cycle);

    sdram_arb_prio u_prio (
        .dl_req_i  (dl_req),
        .er_req_i  (er_req),
        .cpu_req_i (cpu_req),
        .starve_i  (starve),
        .winner_o  (winner)
    );

    always_comb begin
        sel_addr = dl_addr;
        sel_din  = dl_din;
        sel_we   = dl_we;
        case (winner)
            GNT_ER: begin
                sel_addr = er_addr;
                sel_din  = er_din;
                sel_we   = er_we;
            end
            GNT_CPU: begin
                sel_addr = AW'(cpu_addr);
                sel_din  = cpu_din;
                sel_we   = cpu_we;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (slot_ena && !cpu_req) begin
            starve_d = '0;
        end else if (arb_now && cpu_req) begin
            if (winner == GNT_CPU) begin
                starve_d = '0;
            end else if (starve_q != '1) begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge sys_clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            starve_q   <= '0;
            grant_q    <= GNT_NONE;
            dl_ack_q   <= 1'b0;
            er_ack_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            rd_data_q  <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            mem_oe_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            dl_ack_q  <= 1'b0;
            er_ack_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            starve_q  <= starve_d;

            if (slot_ena && (state_q == ST_ACCESS) && !last_cycle) begin
                overrun_q <= 1'b1;
            end

            if (last_cycle) begin
                dl_ack_q  <= (grant_q == GNT_DL);
                er_ack_q  <= (grant_q == GNT_ER);
                cpu_ack_q <= (grant_q == GNT_CPU);
                if (mem_oe_q) begin
                    rd_data_q <= mem_dout;
                end
            end

            if (arb_now) begin
                state_q    <= ST_ACCESS;
                cnt_q      <= '0;
                grant_q    <= winner;
                mem_addr_q <= sel_addr;
                mem_din_q  <= sel_din;
                mem_we_q   <= sel_we;
                mem_oe_q   <= ~sel_we;
            end else if (last_cycle) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                grant_q  <= GNT_NONE;
                mem_we_q <= 1'b0;
                mem_oe_q <= 1'b0;
            end else if (state_q == ST_ACCESS) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign dl_ack       = dl_ack_q;
    assign er_ack       = er_ack_q;
    assign cpu_ack      = cpu_ack_q;
    assign rd_data      = rd_data_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;
    assign mem_we       = mem_we_q;
    assign mem_oe       = mem_oe_q;
    assign grant        = grant_q;
    assign slot_overrun = overrun_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a table of single-slot transactions plus
// hand-written sequences for starvation, back-to-back slots, overrun and reset.
module tb_sdram_arbiter;

    localparam int AW = 25;

    logic          sys_clock = 1'b0;
    logic          reset_n, slot_ena;
    logic          dl_req, dl_we, er_req, er_we, cpu_req, cpu_we;
    logic [AW-1:0] dl_addr, er_addr;
    logic [15:0]   cpu_addr;
    logic [7:0]    dl_din, er_din, cpu_din, mem_dout;
    logic          dl_ack, er_ack, cpu_ack, mem_we, mem_oe, slot_overrun;
    logic [7:0]    rd_data, mem_din;
    logic [AW-1:0] mem_addr;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_pass   = 0;
    int dl_acks = 0, er_acks = 0, cpu_acks = 0, multi_ack = 0;

    always #5 sys_clock = ~sys_clock;

    sdram_arbiter #(.AW(AW), .SLOT_CYCLES(8), .STARVE_LIMIT(4)) dut (
        .sys_clock    (sys_clock),
        .reset_n      (reset_n),
        .slot_ena     (slot_ena),
        .dl_req       (dl_req),
        .dl_we        (dl_we),
        .dl_addr      (dl_addr),
        .dl_din       (dl_din),
        .er_req       (er_req),
        .er_we        (er_we),
        .er_addr      (er_addr),
        .er_din       (er_din),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_din      (cpu_din),
        .dl_ack       (dl_ack),
        .er_ack       (er_ack),
        .cpu_ack      (cpu_ack),
        .rd_data      (rd_data),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_we       (mem_we),
        .mem_oe       (mem_oe),
        .mem_dout     (mem_dout),
        .grant        (grant),
        .slot_overrun (slot_overrun)
    );

    always @(negedge sys_clock) begin
        if (dl_ack)  dl_acks++;
        if (er_ack)  er_acks++;
        if (cpu_ack) cpu_acks++;
        if ($countones({dl_ack, er_ack, cpu_ack}) > 1) multi_ack++;
    end

    typedef struct {
        logic [2:0]    req;      // {dl, er, cpu}
        logic [2:0]    we;       // {dl, er, cpu}
        logic [AW-1:0] dl_addr;
        logic [AW-1:0] er_addr;
        logic [15:0]   cpu_addr;
        logic [7:0]    dl_din;
        logic [7:0]    er_din;
        logic [7:0]    cpu_din;
        logic [7:0]    dout;
        logic [1:0]    exp_grant;
        logic [AW-1:0] exp_addr;
        logic [7:0]    exp_din;
        logic          exp_we;
        logic [7:0]    exp_rd;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic pulse_slot();
        slot_ena = 1'b1;
        step();
        slot_ena = 1'b0;
    endtask

    task automatic clear_reqs();
        dl_req = 1'b0; er_req = 1'b0; cpu_req = 1'b0;
        dl_we  = 1'b0; er_we  = 1'b0; cpu_we  = 1'b0;
    endtask

    function automatic logic [2:0] ack_vec();
        return {dl_ack, er_ack, cpu_ack};
    endfunction

    function automatic logic [2:0] ack_of(input logic [1:0] g);
        case (g)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // One full slot with requests already applied: grant at the slot edge,
    // no ack for 7 cycles, ack exactly 8 cycles after the slot edge.
    task automatic run_access(input logic [1:0] g, input string tag);
        pulse_slot();
        check({tag, "_grant"}, 32'(grant), 32'(g));
        repeat (7) step();
        check({tag, "_early_ack"}, 32'(ack_vec()), 32'd0);
        step();
        check({tag, "_ack"}, 32'(ack_vec()), 32'(ack_of(g)));
        check({tag, "_grant_end"}, 32'(grant), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cpu_before;

        vecs[0] = '{3'b001, 3'b000, 25'h0000000, 25'h0000000, 16'h1234, 8'h00, 8'h00, 8'h00,
                    8'hA5, 2'd3, 25'h0001234, 8'h00, 1'b0, 8'hA5};
        vecs[1] = '{3'b101, 3'b100, 25'h0000100, 25'h0000000, 16'h4321, 8'h3C, 8'h00, 8'h55,
                    8'h11, 2'd1, 25'h0000100, 8'h3C, 1'b1, 8'hA5};
        vecs[2] = '{3'b011, 3'b000, 25'h0000000, 25'h1ABCDEF, 16'h0F0F, 8'h00, 8'h66, 8'h77,
                    8'h5A, 2'd2, 25'h1ABCDEF, 8'h66, 1'b0, 8'h5A};
        vecs[3] = '{3'b111, 3'b011, 25'h0FFFFFF, 25'h0000042, 16'h8000, 8'h12, 8'h34, 8'h56,
                    8'hC3, 2'd1, 25'h0FFFFFF, 8'h12, 1'b0, 8'hC3};
        vecs[4] = '{3'b010, 3'b010, 25'h0000000, 25'h0000042, 16'h0000, 8'h00, 8'h99, 8'h00,
                    8'h22, 2'd2, 25'h0000042, 8'h99, 1'b1, 8'hC3};
        vecs[5] = '{3'b001, 3'b001, 25'h0000000, 25'h0000000, 16'hFFFF, 8'h00, 8'h00, 8'hE7,
                    8'h44, 2'd3, 25'h000FFFF, 8'hE7, 1'b1, 8'hC3};

        reset_n = 1'b0; slot_ena = 1'b0;
        clear_reqs();
        dl_addr = '0; er_addr = '0; cpu_addr = '0;
        dl_din = '0; er_din = '0; cpu_din = '0; mem_dout = '0;
        repeat (3) step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_we_oe", 32'({mem_we, mem_oe}), 32'd0);
        check("rst_addr_din", 32'({mem_addr, mem_din}), 32'd0);
        check("rst_rd_ovr_ack", 32'({rd_data, slot_overrun, ack_vec()}), 32'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            {dl_req, er_req, cpu_req} = vecs[i].req;
            {dl_we, er_we, cpu_we}    = vecs[i].we;
            dl_addr  = vecs[i].dl_addr;
            er_addr  = vecs[i].er_addr;
            cpu_addr = vecs[i].cpu_addr;
            dl_din   = vecs[i].dl_din;
            er_din   = vecs[i].er_din;
            cpu_din  = vecs[i].cpu_din;
            mem_dout = vecs[i].dout;
            pulse_slot();
            check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_din", i), 32'(mem_din), 32'(vecs[i].exp_din));
            check($sformatf("v%0d_we_oe", i), 32'({mem_we, mem_oe}),
                  32'({vecs[i].exp_we, ~vecs[i].exp_we}));
            repeat (7) step();
            check($sformatf("v%0d_hold_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_hold_we_oe", i), 32'({mem_we, mem_oe}),
                  32'({vecs[i].exp_we, ~vecs[i].exp_we}));
            check($sformatf("v%0d_early_ack", i), 32'(ack_vec()), 32'd0);
            step();
            check($sformatf("v%0d_ack", i), 32'(ack_vec()), 32'(ack_of(vecs[i].exp_grant)));
            check($sformatf("v%0d_end_grant", i), 32'(grant), 32'd0);
            check($sformatf("v%0d_end_we_oe", i), 32'({mem_we, mem_oe}), 32'd0);
            check($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
            clear_reqs();
            mem_dout = 8'hFF;
            pulse_slot();
            check($sformatf("v%0d_idle_ack", i), 32'(ack_vec()), 32'd0);
            check($sformatf("v%0d_idle_grant", i), 32'(grant), 32'd0);
            check($sformatf("v%0d_idle_we_oe", i), 32'({mem_we, mem_oe}), 32'd0);
            check($sformatf("v%0d_idle_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
        end

        // Eraser and CPU both held: eraser wins 4 slots, CPU forced on the 5th.
        er_req = 1'b1; er_addr = 25'h0000200;
        cpu_req = 1'b1; cpu_addr = 16'h0300; mem_dout = 8'h10;
        for (int i = 0; i < 6; i++) begin
            run_access((i == 4) ? 2'd3 : 2'd2, $sformatf("starve%0d", i));
        end
        clear_reqs();
        pulse_slot();

        // Downloader write beats CPU; CPU gets the following slot.
        dl_req = 1'b1; dl_we = 1'b1; dl_addr = 25'h0000100; dl_din = 8'h3C;
        cpu_req = 1'b1; cpu_addr = 16'h0ABC; mem_dout = 8'h5C;
        run_access(2'd1, "dlcpu1");
        dl_req = 1'b0; dl_we = 1'b0;
        run_access(2'd3, "dlcpu2");
        check("dlcpu_rd_data", 32'(rd_data), 32'h5C);
        cpu_req = 1'b0;

        // Back-to-back slots every 8 cycles with cpu_req held.
        cpu_req = 1'b1; cpu_addr = 16'h0777; mem_dout = 8'h3E;
        pulse_slot();
        check("b2b_first_grant", 32'(grant), 32'd3);
        for (int k = 0; k < 3; k++) begin
            repeat (7) step();
            check($sformatf("b2b%0d_early_ack", k), 32'(ack_vec()), 32'd0);
            slot_ena = 1'b1;
            step();
            slot_ena = 1'b0;
            check($sformatf("b2b%0d_ack", k), 32'(ack_vec()), 32'b001);
            check($sformatf("b2b%0d_no_gap", k), 32'({grant, mem_oe}), 32'({2'd3, 1'b1}));
        end
        repeat (7) step();
        step();
        check("b2b_last_ack", 32'(ack_vec()), 32'b001);
        check("b2b_last_grant", 32'(grant), 32'd0);
        check("b2b_no_overrun", 32'(slot_overrun), 32'd0);
        cpu_req = 1'b0;
        step();

        // Slot pulse at counter 3: sticky overrun, no second grant.
        cpu_req = 1'b1; cpu_addr = 16'h0042; mem_dout = 8'h81;
        pulse_slot();
        repeat (3) step();
        dl_req = 1'b1; dl_we = 1'b1; dl_addr = 25'h0000555;
        slot_ena = 1'b1;
        step();
        slot_ena = 1'b0;
        check("ovr_flag", 32'(slot_overrun), 32'd1);
        check("ovr_grant_kept", 32'(grant), 32'd3);
        check("ovr_addr_kept", 32'(mem_addr), 32'h0000042);
        repeat (3) step();
        check("ovr_early_ack", 32'(ack_vec()), 32'd0);
        step();
        check("ovr_ack", 32'(ack_vec()), 32'b001);
        check("ovr_rd_data", 32'(rd_data), 32'h81);
        cpu_req = 1'b0;
        step();
        check("ovr_no_regrant", 32'({grant, ack_vec()}), 32'd0);
        check("ovr_sticky", 32'(slot_overrun), 32'd1);
        dl_req = 1'b0; dl_we = 1'b0;

        // Reset at counter 5 of a CPU read, with a competing slot pulse.
        cpu_req = 1'b1; cpu_addr = 16'h0999; mem_dout = 8'hEE;
        pulse_slot();
        repeat (5) step();
        reset_n = 1'b0; slot_ena = 1'b1;
        step();
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_addr_din", 32'({mem_addr, mem_din}), 32'd0);
        check("mid_rst_we_oe", 32'({mem_we, mem_oe}), 32'd0);
        check("mid_rst_rd_ovr_ack", 32'({rd_data, slot_overrun, ack_vec()}), 32'd0);
        reset_n = 1'b1; slot_ena = 1'b0; cpu_req = 1'b0;
        cpu_before = cpu_acks;
        repeat (10) step();
        check("mid_rst_no_ack", 32'(cpu_acks), 32'(cpu_before));

        check("total_dl_acks", 32'(dl_acks), 32'd3);
        check("total_er_acks", 32'(er_acks), 32'd7);
        check("total_cpu_acks", 32'(cpu_acks), 32'd9);
        check("ack_onehot", 32'(multi_ack), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
